pixel_grid_mapper: RTL and testbench

//   Maps a 9-bit screen pixel coordinate (x,y) to the 4-bit column/row index of
//   the game tile that contains it. Used by game logic and the renderer to find

---
 rtl/pixel_grid_mapper_if.sv | 28 ++
 rtl/pixel_grid_mapper.sv | 129 ++++++++++++
 tb/tb_pixel_grid_mapper.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_grid_mapper_if.sv
// ============================================================================
// Module   : pixel_grid_mapper_if
// Brief    : Coordinate-in / tile-index-out bundle for pixel_grid_mapper.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface pixel_grid_mapper_if;
    logic       valid_in;
    logic [8:0] x_coord;
    logic [8:0] y_coord;
    logic       valid_out;
    logic [3:0] x_grid;
    logic [3:0] y_grid;
    logic       oob;

    modport master (
        output valid_in, x_coord, y_coord,
        input  valid_out, x_grid, y_grid, oob
    );

    modport slave (
        input  valid_in, x_coord, y_coord,
        output valid_out, x_grid, y_grid, oob
    );
endinterface

`default_nettype wire

// File: rtl/pixel_grid_mapper.sv
// ============================================================================
// Module   : pixel_grid_mapper
// Brief    : Two-stage pipeline mapping a pixel (x,y) to its tile column/row.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pixel_grid_mapper #(
    parameter int X_ORIGIN = 0,
    parameter int Y_ORIGIN = 0,
    parameter int TILE_W   = 32,
    parameter int TILE_H   = 32,
    parameter int COLS     = 16,
    parameter int ROWS     = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    pixel_grid_mapper_if.slave   bus
);

    // 14 bits hold 16*511 = 8176 without overflow
    localparam int c_CW     = 14;
    localparam int c_X_SPAN = COLS * TILE_W;
    localparam int c_Y_SPAN = ROWS * TILE_H;

    // Stage 1
    logic               r_s1_valid;
    logic signed [9:0]  r_dx;
    logic signed [9:0]  r_dy;
    logic               r_below_x;
    logic               r_below_y;

    // Stage 2
    logic               r_valid_out;
    logic [3:0]         r_x_grid;
    logic [3:0]         r_y_grid;
    logic               r_oob;

    logic signed [9:0]  w_dx;
    logic signed [9:0]  w_dy;
    logic               w_below_x;
    logic               w_below_y;

    assign w_dx      = {1'b0, bus.x_coord} - 10'(X_ORIGIN);
    assign w_dy      = {1'b0, bus.y_coord} - 10'(Y_ORIGIN);
    assign w_below_x = {1'b0, bus.x_coord} < 10'(X_ORIGIN);
    assign w_below_y = {1'b0, bus.y_coord} < 10'(Y_ORIGIN);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_s1_valid <= 1'b0;
            r_dx       <= '0;
            r_dy       <= '0;
            r_below_x  <= 1'b0;
            r_below_y  <= 1'b0;
        end else begin
            r_s1_valid <= bus.valid_in;
            r_dx       <= w_dx;
            r_dy       <= w_dy;
            r_below_x  <= w_below_x;
            r_below_y  <= w_below_y;
        end
    end

    // Offsets are only meaningful as unsigned once the below-origin flag is clear
    logic [c_CW-1:0] w_dx_ext;
    logic [c_CW-1:0] w_dy_ext;
    assign w_dx_ext = {4'b0000, r_dx};
    assign w_dy_ext = {4'b0000, r_dy};

    logic [COLS-1:0] w_x_ge;
    logic [ROWS-1:0] w_y_ge;

    generate
        for (genvar k = 0; k < COLS; k++) begin : g_x_thr
            assign w_x_ge[k] = w_dx_ext >= c_CW'(k * TILE_W);
        end
        for (genvar k = 0; k < ROWS; k++) begin : g_y_thr
            assign w_y_ge[k] = w_dy_ext >= c_CW'(k * TILE_H);
        end
    endgenerate

    logic [3:0] w_x_idx;
    logic [3:0] w_y_idx;
    logic       w_oob;

    // Thresholds rise with k, so the last one passed is the floor quotient
    always_comb begin
        w_x_idx = '0;
        for (int k = 0; k < COLS; k++) begin
            if (w_x_ge[k]) w_x_idx = 4'(k);
        end
        if (r_below_x) w_x_idx = '0;

        w_y_idx = '0;
        for (int k = 0; k < ROWS; k++) begin
            if (w_y_ge[k]) w_y_idx = 4'(k);
        end
        if (r_below_y) w_y_idx = '0;

        w_oob = r_below_x | r_below_y
              | (w_dx_ext >= c_CW'(c_X_SPAN))
              | (w_dy_ext >= c_CW'(c_Y_SPAN));
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_valid_out <= 1'b0;
            r_x_grid    <= '0;
            r_y_grid    <= '0;
            r_oob       <= 1'b0;
        end else begin
            r_valid_out <= r_s1_valid;
            if (r_s1_valid) begin
                r_x_grid <= w_x_idx;
                r_y_grid <= w_y_idx;
                r_oob    <= w_oob;
            end
        end
    end

    assign bus.valid_out = r_valid_out;
    assign bus.x_grid    = r_x_grid;
    assign bus.y_grid    = r_y_grid;
    assign bus.oob       = r_oob;

endmodule

`default_nettype wire

// File: tb/tb_pixel_grid_mapper.sv
// ============================================================================
// Module   : tb_pixel_grid_mapper
// Brief    : Self-checking bench for pixel_grid_mapper (default and offset grids).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pixel_grid_mapper;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pixel_grid_mapper_if a_if ();
    pixel_grid_mapper_if b_if ();

    pixel_grid_mapper dut_a (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (a_if.slave)
    );

    pixel_grid_mapper #(
        .X_ORIGIN (40),
        .Y_ORIGIN (20),
        .TILE_W   (24),
        .TILE_H   (24),
        .COLS     (10),
        .ROWS     (8)
    ) dut_b (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (b_if.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [9:0] pk(input bit v, input int x, input int y, input bit o);
        return {v, 4'(x), 4'(y), o};
    endfunction

    function automatic logic [9:0] obs_a();
        return {a_if.valid_out, a_if.x_grid, a_if.y_grid, a_if.oob};
    endfunction

    function automatic logic [9:0] obs_b();
        return {b_if.valid_out, b_if.x_grid, b_if.y_grid, b_if.oob};
    endfunction

    // Reference: which tile holds coordinate c, by plain division and clamping
    function automatic void ref_axis(input int c, input int origin, input int tile,
                                     input int n, output int idx, output bit o);
        int q;
        if (c < origin) begin
            idx = 0;
            o   = 1'b1;
        end else begin
            q = (c - origin) / tile;
            if (q >= n) begin
                idx = n - 1;
                o   = 1'b1;
            end else begin
                idx = q;
                o   = 1'b0;
            end
        end
    endfunction

    task automatic step_a(input bit v, input int x, input int y);
        a_if.valid_in = v;
        a_if.x_coord  = 9'(x);
        a_if.y_coord  = 9'(y);
        @(negedge clk);
    endtask

    task automatic step_b(input bit v, input int x, input int y);
        b_if.valid_in = v;
        b_if.x_coord  = 9'(x);
        b_if.y_coord  = 9'(y);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [9:0] got;
        rst = 1'b1;
        a_if.valid_in = 1'b1; a_if.x_coord = 9'd500; a_if.y_coord = 9'd500;
        b_if.valid_in = 1'b1; b_if.x_coord = 9'd500; b_if.y_coord = 9'd500;
        @(negedge clk);
        @(negedge clk);
        got = obs_a();
        n_checks++;
        if (got !== pk(0, 0, 0, 0)) begin
            n_errors++;
            $display("FAIL reset_a: got %h want %h", got, pk(0, 0, 0, 0));
        end
        got = obs_b();
        n_checks++;
        if (got !== pk(0, 0, 0, 0)) begin
            n_errors++;
            $display("FAIL reset_b: got %h want %h", got, pk(0, 0, 0, 0));
        end
        a_if.valid_in = 1'b0;
        b_if.valid_in = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_default_map();
        logic [9:0] got;
        logic [9:0] exp [3] = '{pk(1, 15, 9, 0), pk(1, 3, 9, 0), pk(1, 0, 0, 0)};
        int xs [3] = '{500, 113, 0};
        int ys [3] = '{300, 304, 0};
        for (int i = 0; i < 5; i++) begin
            if (i < 3) step_a(1, xs[i], ys[i]);
            else       step_a(0, 0, 0);
            if (i >= 1 && i <= 3) begin
                got = obs_a();
                n_checks++;
                if (got !== exp[i-1]) begin
                    n_errors++;
                    $display("FAIL default_map_%0d: got %h want %h", i - 1, got, exp[i-1]);
                end
            end
        end
        got = obs_a();
        n_checks++;
        if (got !== pk(0, 0, 0, 0)) begin
            n_errors++;
            $display("FAIL default_hold: got %h want %h", got, pk(0, 0, 0, 0));
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] got;
        logic [9:0] exp [3] = '{pk(1, 0, 0, 0), pk(1, 1, 1, 0), pk(1, 15, 15, 0)};
        int cs [3] = '{31, 32, 511};
        for (int i = 0; i < 5; i++) begin
            if (i < 3) step_a(1, cs[i], cs[i]);
            else       step_a(0, 0, 0);
            if (i >= 1 && i <= 3) begin
                got = obs_a();
                n_checks++;
                if (got !== exp[i-1]) begin
                    n_errors++;
                    $display("FAIL b2b_%0d: got %h want %h", i - 1, got, exp[i-1]);
                end
            end
        end
    endtask

    task automatic test_offset_grid();
        logic [9:0] got;
        logic [9:0] exp [3] = '{pk(1, 0, 3, 1), pk(1, 9, 1, 1), pk(1, 9, 7, 0)};
        int xs [3] = '{10, 300, 279};
        int ys [3] = '{100, 50, 211};
        for (int i = 0; i < 5; i++) begin
            if (i < 3) step_b(1, xs[i], ys[i]);
            else       step_b(0, 0, 0);
            if (i >= 1 && i <= 3) begin
                got = obs_b();
                n_checks++;
                if (got !== exp[i-1]) begin
                    n_errors++;
                    $display("FAIL offset_%0d: got %h want %h", i - 1, got, exp[i-1]);
                end
            end
        end
    endtask

    task automatic test_bubble();
        logic [9:0] got;
        logic [9:0] exp [4] = '{pk(1, 2, 3, 0), pk(0, 2, 3, 0), pk(1, 6, 1, 0), pk(0, 6, 1, 0)};
        bit vs [3] = '{1'b1, 1'b0, 1'b1};
        int xs [3] = '{64, 480, 200};
        int ys [3] = '{96, 480, 40};
        for (int i = 0; i < 5; i++) begin
            if (i < 3) step_a(vs[i], xs[i], ys[i]);
            else       step_a(0, 0, 0);
            if (i >= 1) begin
                got = obs_a();
                n_checks++;
                if (got !== exp[i-1]) begin
                    n_errors++;
                    $display("FAIL bubble_%0d: got %h want %h", i - 1, got, exp[i-1]);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [9:0] got;
        step_a(1, 100, 100);
        step_a(1, 200, 200);
        rst = 1'b1;
        step_a(0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            got = obs_a();
            n_checks++;
            if (got !== pk(0, 0, 0, 0)) begin
                n_errors++;
                $display("FAIL midreset_%0d: got %h want %h", i, got, pk(0, 0, 0, 0));
            end
            step_a(0, 0, 0);
        end
    endtask

    task automatic test_random();
        bit hv [2];
        int hax [2], hay [2], hbx [2], hby [2];
        logic [9:0] last_a, last_b, exp_a, exp_b, got;
        int ix, iy;
        bit ox, oy;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_a = pk(0, 0, 0, 0);
        last_b = pk(0, 0, 0, 0);
        hv[0] = 1'b0;
        hv[1] = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (hv[1]) begin
                ref_axis(hax[1], 0, 32, 16, ix, ox);
                ref_axis(hay[1], 0, 32, 16, iy, oy);
                exp_a  = pk(1, ix, iy, ox | oy);
                last_a = pk(0, ix, iy, ox | oy);
                ref_axis(hbx[1], 40, 24, 10, ix, ox);
                ref_axis(hby[1], 20, 24, 8, iy, oy);
                exp_b  = pk(1, ix, iy, ox | oy);
                last_b = pk(0, ix, iy, ox | oy);
            end else begin
                exp_a = last_a;
                exp_b = last_b;
            end
            got = obs_a();
            n_checks++;
            if (got !== exp_a) begin
                n_errors++;
                $display("FAIL rand_a cyc %0d: got %h want %h", cyc, got, exp_a);
            end
            got = obs_b();
            n_checks++;
            if (got !== exp_b) begin
                n_errors++;
                $display("FAIL rand_b cyc %0d: got %h want %h", cyc, got, exp_b);
            end
            hv[1] = hv[0]; hax[1] = hax[0]; hay[1] = hay[0];
            hbx[1] = hbx[0]; hby[1] = hby[0];
            hv[0]  = ($urandom_range(3) != 0);
            hax[0] = $urandom_range(511);
            hay[0] = $urandom_range(511);
            // Half the B samples land within one pixel of a tile edge
            if ($urandom_range(1) == 1) begin
                hbx[0] = 40 + 24 * $urandom_range(10) + $urandom_range(2) - 1;
                hby[0] = 20 + 24 * $urandom_range(8) + $urandom_range(2) - 1;
            end else begin
                hbx[0] = $urandom_range(511);
                hby[0] = $urandom_range(511);
            end
            a_if.valid_in = hv[0];
            a_if.x_coord  = 9'(hax[0]);
            a_if.y_coord  = 9'(hay[0]);
            b_if.valid_in = hv[0];
            b_if.x_coord  = 9'(hbx[0]);
            b_if.y_coord  = 9'(hby[0]);
            @(negedge clk);
        end
    endtask

    initial begin
        a_if.valid_in = 1'b0; a_if.x_coord = '0; a_if.y_coord = '0;
        b_if.valid_in = 1'b0; b_if.x_coord = '0; b_if.y_coord = '0;
        @(negedge clk);
        test_reset();
        test_default_map();
        test_back_to_back();
        test_offset_grid();
        test_bubble();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
